// File: rtl/aes_pkg.sv
// Shared AES GF(2^8) helpers, MixColumns coefficients and the serial engine's state encoding.
package aes_pkg;

   // Coefficient j multiplies row (r+j) mod 4 of the column
   localparam logic [3:0][3:0] FWD_COEF = {4'h1, 4'h1, 4'h3, 4'h2};
   localparam logic [3:0][3:0] INV_COEF = {4'h9, 4'hd, 4'hb, 4'he};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } mc_state_t;

   function automatic logic [7:0] xt2(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul4(input logic [7:0] b, input logic [3:0] c);
      logic [7:0] acc;
      logic [7:0] p;
      acc = 8'h00;
      p   = b;
      for (int i = 0; i < 4; i++) begin
         if (c[i]) acc = acc ^ p;
         p = xt2(p);
      end
      return acc;
   endfunction

endpackage

// File: rtl/aes_mixcolumn_lane.sv
// One output byte of (Inv)MixColumns: selected row of a 32-bit column.
module aes_mixcolumn_lane
   import aes_pkg::*;
(
   input  logic [31:0] column,
   input  logic [1:0]  row,
   input  logic        dec,
   output logic [7:0]  byte_out
);

   logic [3:0][7:0] col_b;
   logic [3:0][3:0] coef;

   assign col_b = column;
   assign coef  = dec ? INV_COEF : FWD_COEF;

   always_comb begin
      logic [1:0] rj;
      byte_out = 8'h00;
      for (int j = 0; j < 4; j++) begin
         rj       = row + 2'(j);
         byte_out = byte_out ^ gf_mul4(col_b[rj], coef[j]);
      end
   end

endmodule

// File: rtl/aes_mixcolumn_serial.sv
// Iterative MixColumns/InvMixColumns over a 128-bit state, LANES output bytes per cycle.
module aes_mixcolumn_serial
   import aes_pkg::*;
#(
   parameter int LANES = 1
) (
   input  logic         g_clk,
   input  logic         g_rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         in_dec,
   input  logic [127:0] in_state,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state,
   output logic         busy
);

   localparam int N  = 16 / LANES;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   mc_state_t         state;
   logic [CW-1:0]     cnt;
   logic [3:0][31:0]  in_q;
   logic              dec_q;
   logic [15:0][7:0]  out_q;

   logic [LANES-1:0][3:0] lane_k;
   logic [LANES-1:0][7:0] lane_b;

   generate
      for (genvar g = 0; g < LANES; g++) begin : g_lane
         assign lane_k[g] = 4'(int'(cnt) * LANES + g);
         aes_mixcolumn_lane u_lane (
            .column   (in_q[lane_k[g][3:2]]),
            .row      (lane_k[g][1:0]),
            .dec      (dec_q),
            .byte_out (lane_b[g])
         );
      end
   endgenerate

   // in_q is frozen through RUN so every byte sees the original columns
   always_ff @(posedge g_clk) begin
      if (g_rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
         in_q  <= '0;
         dec_q <= 1'b0;
         out_q <= '0;
      end else begin
         case (state)
            ST_IDLE: if (in_valid) begin
               in_q  <= in_state;
               dec_q <= in_dec;
               cnt   <= '0;
               state <= ST_RUN;
            end
            ST_RUN: begin
               for (int l = 0; l < LANES; l++) out_q[lane_k[l]] <= lane_b[l];
               if (cnt == CW'(N - 1)) begin
                  cnt   <= '0;
                  state <= ST_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_DONE: if (out_ready) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready  = (state == ST_IDLE) && !g_rst;
   assign out_valid = (state == ST_DONE);
   assign busy      = (state != ST_IDLE);
   assign out_state = out_q;

endmodule

// File: tb/tb_aes_mixcolumn_serial.sv
// Directed bench for aes_mixcolumn_serial: LANES=1 main instance plus a LANES=4 shadow on shared inputs.
module tb_aes_mixcolumn_serial;

   logic         g_clk = 1'b0;
   logic         g_rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_dec = 1'b0;
   logic [127:0] in_state = '0;
   logic         out_ready = 1'b0;
   logic         in_ready, out_valid, busy;
   logic [127:0] out_state;
   logic         in_ready4, out_valid4, busy4;
   logic [127:0] out_state4;

   int checks = 0;
   int failures = 0;

   localparam logic [127:0] V  = 128'h01010101_01010101_5c220af2_455313db;
   localparam logic [127:0] E  = 128'h01010101_01010101_9d58dc9f_bca14d8e;
   localparam logic [127:0] C6 = {4{32'hc6c6c6c6}};

   always #5 g_clk = ~g_clk;

   aes_mixcolumn_serial #(.LANES(1)) u_dut (
      .g_clk(g_clk), .g_rst(g_rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_dec(in_dec), .in_state(in_state), .out_valid(out_valid),
      .out_ready(out_ready), .out_state(out_state), .busy(busy)
   );

   aes_mixcolumn_serial #(.LANES(4)) u_dut4 (
      .g_clk(g_clk), .g_rst(g_rst), .in_valid(in_valid), .in_ready(in_ready4),
      .in_dec(in_dec), .in_state(in_state), .out_valid(out_valid4),
      .out_ready(out_ready), .out_state(out_state4), .busy(busy4)
   );

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h", tag, act, exp);
      end
   endtask

   // Accept one state, time the result, check it, then hand it off
   task automatic run_one(input string tag, input logic dec, input logic [127:0] st,
                          input logic [127:0] exp, input bit chk4);
      int n, n4;
      logic [127:0] r4;
      @(negedge g_clk);
      in_valid = 1'b1; in_dec = dec; in_state = st;
      @(negedge g_clk);
      in_valid = 1'b0; in_state = '0;
      n = 0; n4 = -1; r4 = '0;
      while (!out_valid && n < 100) begin
         @(negedge g_clk);
         n++;
         if (out_valid4 && n4 < 0) begin n4 = n; r4 = out_state4; end
      end
      chk({tag, "_lat"}, 128'(n), 128'd16);
      chk({tag, "_data"}, out_state, exp);
      if (chk4) begin
         chk({tag, "_lat4"}, 128'(n4), 128'd4);
         chk({tag, "_data4"}, r4, exp);
      end
      out_ready = 1'b1;
      @(negedge g_clk);
      out_ready = 1'b0;
      chk({tag, "_ov_drop"}, 128'(out_valid), 128'd0);
      chk({tag, "_rdy_back"}, 128'(in_ready), 128'd1);
   endtask

   initial begin
      int seen;
      int nacc, ncomp;
      int tc[2];
      logic [127:0] bb_st[2], bb_exp[2];
      logic         bb_dec[2];

      repeat (2) @(negedge g_clk);
      chk("rst_in_ready", 128'(in_ready), 128'd0);
      chk("rst_out_valid", 128'(out_valid), 128'd0);
      chk("rst_busy", 128'(busy), 128'd0);
      chk("rst_out_state", out_state, 128'd0);
      g_rst = 1'b0;
      #1;
      chk("idle_in_ready", 128'(in_ready), 128'd1);

      run_one("enc", 1'b0, V, E, 1'b1);
      run_one("dec", 1'b1, E, V, 1'b0);
      run_one("c6_enc", 1'b0, C6, C6, 1'b0);
      run_one("c6_dec", 1'b1, C6, C6, 1'b0);

      // Backpressure: result held, new requests refused
      @(negedge g_clk);
      in_valid = 1'b1; in_dec = 1'b0; in_state = V;
      @(negedge g_clk);
      in_state = C6;
      seen = 0;
      while (!out_valid && seen < 100) begin @(negedge g_clk); seen++; end
      for (int i = 0; i < 20; i++) begin
         chk("bp_valid", 128'(out_valid), 128'd1);
         chk("bp_data", out_state, E);
         chk("bp_in_ready", 128'(in_ready), 128'd0);
         @(negedge g_clk);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge g_clk);
      out_ready = 1'b0;
      chk("bp_ov_drop", 128'(out_valid), 128'd0);
      chk("bp_rdy_back", 128'(in_ready), 128'd1);
      chk("bp_hold", out_state, E);
      @(negedge g_clk);
      chk("bp_no_accept", 128'(busy), 128'd0);

      // Reset at count 7
      in_valid = 1'b1; in_dec = 1'b0; in_state = V;
      @(negedge g_clk);
      in_valid = 1'b0;
      repeat (7) @(negedge g_clk);
      g_rst = 1'b1;
      @(negedge g_clk);
      g_rst = 1'b0;
      #1;
      chk("mid_rst_ov", 128'(out_valid), 128'd0);
      chk("mid_rst_state", out_state, 128'd0);
      chk("mid_rst_rdy", 128'(in_ready), 128'd1);
      seen = 0;
      repeat (20) begin @(negedge g_clk); if (out_valid) seen++; end
      chk("mid_rst_no_pulse", 128'(seen), 128'd0);
      run_one("post_rst", 1'b0, V, E, 1'b0);

      // Back-to-back with out_ready tied high
      bb_st[0] = V; bb_dec[0] = 1'b0; bb_exp[0] = E;
      bb_st[1] = E; bb_dec[1] = 1'b1; bb_exp[1] = V;
      tc[0] = 0; tc[1] = 0;
      nacc = 0; ncomp = 0;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 60; cyc++) begin
         @(negedge g_clk);
         if (out_valid && ncomp < 2) begin
            chk("b2b_data", out_state, bb_exp[ncomp]);
            tc[ncomp] = cyc;
            ncomp++;
         end
         if (in_ready && nacc < 2) begin
            in_valid = 1'b1; in_state = bb_st[nacc]; in_dec = bb_dec[nacc];
            nacc++;
         end else begin
            in_valid = 1'b0;
         end
      end
      out_ready = 1'b0;
      chk("b2b_count", 128'(ncomp), 128'd2);
      chk("b2b_spacing", 128'(tc[1] - tc[0]), 128'd18);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
